dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the single-cycle CPU's load/store path. It is the target side of a request/acknowledge data bus: it accepts one word access per transaction, inserts a programmable number of wait states, then returns read data or commits write data with a one-cycle acknowledge. Misaligned or out-of-range addresses are flagged with an error response. It replaces the zero-latency data memory when the core is moved to a stalling memory interface.

---
 rtl/dmem_if.sv | 7 +
 rtl/dmem_responder.sv | 61 ++++++
 tb/tb_dmem_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: request/acknowledge data bus between a core and its data memory
interface dmem_if;
  logic req, we, ack, err, busy;
  logic [31:0] addr, wdata, rdata;
  modport master (output req, we, addr, wdata, input rdata, ack, err, busy);
  modport slave (input req, we, addr, wdata, output rdata, ack, err, busy);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target with wait states and error response
module dmem_responder #(
  parameter int ADDR_W = 6,
  parameter int WAIT_CYC = 2
) (
  input logic clk,
  input logic pcrst,
  dmem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic rest, we_q, ack, err;
  logic [31:0] addr_q, wdata_q, rdata;
  logic [31:0] mem [2**ADDR_W];
  logic go, enter, a_we, a_bad;
  logic [31:0] a_addr, a_wdata;
  logic [ADDR_W-1:0] idx;
  // in IDLE the live bus fields are used so a zero-wait access can respond on its acceptance edge
  always_comb begin
    go = state == IDLE && bus.req && !rest;
    a_we = state == IDLE ? bus.we : we_q;
    a_addr = state == IDLE ? bus.addr : addr_q;
    a_wdata = state == IDLE ? bus.wdata : wdata_q;
    a_bad = a_addr[1:0] != 2'b0 || (a_addr >> (ADDR_W + 2)) != 32'b0;
    idx = a_addr[ADDR_W+1:2];
    enter = (go && WAIT_CYC == 0) || (state == WAIT && cnt == 4'd1);
  end
  // transaction FSM, memory array and registered response; rest enforces one idle cycle after each response
  always_ff @(posedge clk or posedge pcrst) begin
    if (pcrst) begin
      state <= IDLE;
      cnt <= '0;
      rest <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata <= '0;
      ack <= 1'b0;
      err <= 1'b0;
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else begin
      ack <= enter;
      err <= enter && a_bad;
      rest <= state == RESP;
      if (enter) rdata <= (a_bad || a_we) ? 32'b0 : mem[idx];
      if (enter && a_we && !a_bad) mem[idx] <= a_wdata;
      if (go) begin
        we_q <= bus.we;
        addr_q <= bus.addr;
        wdata_q <= bus.wdata;
      end
      cnt <= go ? 4'(WAIT_CYC) : state == WAIT ? cnt - 4'd1 : cnt;
      state <= enter ? RESP : go ? WAIT : state == WAIT ? WAIT : IDLE;
    end
  end
  assign bus.rdata = rdata;
  assign bus.ack = ack;
  assign bus.err = err;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at 0, 2 and 4 wait states
module tb_dmem_responder;
  logic clk, pcrst, req, we;
  logic [31:0] addr, wdata;
  int cw, checks, errors;
  logic s_ack, s_err, s_busy;
  logic [31:0] s_rdata, rd;
  logic e;
  int lat, first, second, nack;
  dmem_if b0 ();
  dmem_if b2 ();
  dmem_if b4 ();
  assign b0.req = req;
  assign b0.we = we;
  assign b0.addr = addr;
  assign b0.wdata = wdata;
  assign b2.req = req;
  assign b2.we = we;
  assign b2.addr = addr;
  assign b2.wdata = wdata;
  assign b4.req = req;
  assign b4.we = we;
  assign b4.addr = addr;
  assign b4.wdata = wdata;
  dmem_responder #(.ADDR_W(6), .WAIT_CYC(0)) d0 (.clk(clk), .pcrst(pcrst), .bus(b0));
  dmem_responder #(.ADDR_W(6), .WAIT_CYC(2)) d2 (.clk(clk), .pcrst(pcrst), .bus(b2));
  dmem_responder #(.ADDR_W(6), .WAIT_CYC(4)) d4 (.clk(clk), .pcrst(pcrst), .bus(b4));
  assign s_ack = cw == 0 ? b0.ack : cw == 2 ? b2.ack : b4.ack;
  assign s_err = cw == 0 ? b0.err : cw == 2 ? b2.err : b4.err;
  assign s_busy = cw == 0 ? b0.busy : cw == 2 ? b2.busy : b4.busy;
  assign s_rdata = cw == 0 ? b0.rdata : cw == 2 ? b2.rdata : b4.rdata;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    pcrst = 1'b1;
    repeat (2) @(negedge clk);
    pcrst = 1'b0;
  endtask
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] r, output logic er, output int l);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    l = 0; r = 'x; er = 1'bx;
    for (int i = 1; i <= 20 && l == 0; i++) begin
      @(negedge clk);
      if (i == 1) req = 1'b0;
      if (s_ack) begin
        l = i; r = s_rdata; er = s_err;
      end
    end
    repeat (2) @(negedge clk);
  endtask
  initial begin
    checks = 0; errors = 0; cw = 2;
    pcrst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_ack", s_ack, 0);
    chk("rst_err", s_err, 0);
    chk("rst_busy", s_busy, 0);
    pcrst = 1'b0;
    access(1'b1, 32'h10, 32'hA5A5A5A5, rd, e, lat);
    chk("st10_lat", lat, 3);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10;
    @(negedge clk);
    req = 1'b0;
    chk("ld10_busy", s_busy, 1);
    repeat (2) @(negedge clk);
    chk("ld10_ack", s_ack, 1);
    chk("ld10_rdata", s_rdata, 32'hA5A5A5A5);
    pcrst = 1'b1;
    #1;
    chk("async_rdata", s_rdata, 0);
    chk("async_ack", s_ack, 0);
    chk("async_err", s_err, 0);
    chk("async_busy", s_busy, 0);
    #2 pcrst = 1'b0;
    @(negedge clk);
    access(1'b0, 32'h10, 32'h0, rd, e, lat);
    chk("clr10_rdata", rd, 0);
    chk("clr10_lat", lat, 3);
    access(1'b1, 32'h8, 32'hDEADBEEF, rd, e, lat);
    chk("st8_lat", lat, 3);
    chk("st8_err", e, 0);
    chk("st8_rdata", rd, 0);
    access(1'b0, 32'h8, 32'h0, rd, e, lat);
    chk("ld8_rdata", rd, 32'hDEADBEEF);
    chk("ld8_err", e, 0);
    access(1'b1, 32'h6, 32'h12345678, rd, e, lat);
    chk("mis_lat", lat, 3);
    chk("mis_err", e, 1);
    chk("mis_rdata", rd, 0);
    access(1'b0, 32'h4, 32'h0, rd, e, lat);
    chk("ld4_rdata", rd, 0);
    chk("ld4_err", e, 0);
    access(1'b0, 32'h100, 32'h0, rd, e, lat);
    chk("oor_err", e, 1);
    chk("oor_rdata", rd, 0);
    access(1'b1, 32'hFC, 32'h11223344, rd, e, lat);
    chk("stfc_err", e, 0);
    access(1'b0, 32'hFC, 32'h0, rd, e, lat);
    chk("ldfc_rdata", rd, 32'h11223344);
    chk("ldfc_err", e, 0);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h8;
    @(negedge clk);
    req = 1'b0; we = 1'b1; addr = 32'hFFFF_FFF1; wdata = 32'h55555555;
    @(negedge clk);
    chk("drop_noack", s_ack, 0);
    @(negedge clk);
    chk("drop_ack", s_ack, 1);
    chk("drop_rdata", s_rdata, 32'hDEADBEEF);
    chk("drop_err", s_err, 0);
    @(negedge clk);
    chk("drop_ackfall", s_ack, 0);
    chk("drop_busyfall", s_busy, 0);
    chk("drop_rdhold", s_rdata, 32'hDEADBEEF);
    @(negedge clk);
    cw = 0;
    do_reset();
    access(1'b1, 32'h20, 32'h0BADF00D, rd, e, lat);
    chk("w0_st_lat", lat, 1);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h20;
    first = 0; second = 0; rd = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (s_ack) begin
        if (first == 0) begin
          first = i; rd = s_rdata;
        end else if (second == 0) second = i;
      end
    end
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_first", first, 1);
    chk("held_second", second, 4);
    chk("held_rdata", rd, 32'h0BADF00D);
    cw = 4;
    do_reset();
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    pcrst = 1'b1;
    #1;
    chk("abort_busy", s_busy, 0);
    @(negedge clk);
    pcrst = 1'b0;
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_ack) nack++;
    end
    chk("abort_noack", nack, 0);
    access(1'b0, 32'h0, 32'h0, rd, e, lat);
    chk("abort_rdata", rd, 0);
    chk("w4_lat", lat, 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
